mem_ctrl: RTL

Memory controller between the CPU core's two memory clients, instruction fetch (IF) and the load/store buffer (LSB), and the single byte-wide RAM/IO port of `riscv_top`. It arbitrates the shared port, serialises each 1/2/4-byte access into byte transfers (little-endian), handles pause, rollback and IO back-pressure, and returns assembled words with a one-cycle done pulse.

---
 rtl/mem_ctrl_pkg.sv | 27 ++
 rtl/mem_ctrl_arb.sv | 38 +++
 rtl/mem_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: FSM state type, lsb_len encodings, byte-count helper and
// IO region constant shared by the memory controller files.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } mc_state_e;

  localparam logic [1:0] LEN_B1    = 2'd0;
  localparam logic [1:0] LEN_B2    = 2'd1;
  localparam logic [1:0] LEN_B4    = 2'd2;
  localparam logic [1:0] IO_REGION = 2'b11;
  localparam logic [2:0] IF_BYTES  = 3'd4;

  // Encoding 3 is reserved and behaves as a full word.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_B1:  len_bytes = 3'd1;
      LEN_B2:  len_bytes = 3'd2;
      LEN_B4:  len_bytes = 3'd4;
      default: len_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_arb.sv
// mem_ctrl_arb: grant logic for the IF and LSB clients.
// MEM_CTRL_RR_EN selects round-robin; otherwise fixed priority, LSB over IF.
module mem_ctrl_arb (
`ifdef MEM_CTRL_RR_EN
  input  logic clk_in,
  input  logic rst_in,
  input  logic take,
`endif
  input  logic if_req,
  input  logic lsb_req,
  output logic gnt_if,
  output logic gnt_lsb
);

`ifdef MEM_CTRL_RR_EN
  // Starts pointing at LSB so IF wins the first tie after reset.
  logic last_lsb;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      last_lsb <= 1'b1;
    end else if (take) begin
      last_lsb <= gnt_lsb;
    end
  end

  always_comb begin
    gnt_if  = if_req && (!lsb_req || last_lsb);
    gnt_lsb = lsb_req && !gnt_if;
  end
`else
  always_comb begin
    gnt_lsb = lsb_req;
    gnt_if  = if_req && !lsb_req;
  end
`endif

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates IF and LSB onto the byte-wide RAM/IO port, serialising
// accesses little-endian. Build option MEM_CTRL_RR_EN enables round-robin.
//
// state | meaning
// IDLE  | no transaction; arbitrate and latch request fields
// BUSY  | one byte addressed per cycle; loads spend one extra cycle capturing
// DONE  | one-cycle done pulse to the granted client
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [1:0] IO_HI = IO_REGION
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rollback_in,
  input  logic        if_req_valid,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        lsb_req_valid,
  input  logic        lsb_wr,
  input  logic [1:0]  lsb_len,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_done,
  output logic [31:0] lsb_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  mc_state_e   state, state_nx;
  logic [2:0]  cnt, cnt_nx, nbytes, nbytes_nx, a_idx;
  logic        is_if, is_if_nx, is_wr, is_wr_nx;
  logic [31:0] addr, addr_nx, wdata, wdata_nx, data, data_nx;
  logic        gnt_if, gnt_lsb, take, abort, io_stall;

  assign take     = (state == ST_IDLE) && rdy_in && !rollback_in &&
                    (if_req_valid || lsb_req_valid);
  assign abort    = rollback_in && (state != ST_IDLE) && !is_wr;
  assign io_stall = (state == ST_BUSY) && is_wr &&
                    (addr[17:16] == IO_HI) && io_buffer_full;

  mem_ctrl_arb u_arb (
`ifdef MEM_CTRL_RR_EN
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .take    (take),
`endif
    .if_req  (if_req_valid),
    .lsb_req (lsb_req_valid),
    .gnt_if  (gnt_if),
    .gnt_lsb (gnt_lsb)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state  <= ST_IDLE;
      cnt    <= 3'd0;
      nbytes <= 3'd0;
      is_if  <= 1'b0;
      is_wr  <= 1'b0;
      addr   <= 32'd0;
      wdata  <= 32'd0;
      data   <= 32'd0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      nbytes <= nbytes_nx;
      is_if  <= is_if_nx;
      is_wr  <= is_wr_nx;
      addr   <= addr_nx;
      wdata  <= wdata_nx;
      data   <= data_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    nbytes_nx = nbytes;
    is_if_nx  = is_if;
    is_wr_nx  = is_wr;
    addr_nx   = addr;
    wdata_nx  = wdata;
    data_nx   = data;
    if (abort) begin
      state_nx = ST_IDLE;
    end else if (rdy_in) begin
      case (state)
        ST_IDLE: begin
          if (take) begin
            state_nx  = ST_BUSY;
            cnt_nx    = 3'd0;
            is_if_nx  = gnt_if;
            is_wr_nx  = gnt_lsb && lsb_wr;
            addr_nx   = gnt_if ? if_addr : lsb_addr;
            wdata_nx  = lsb_wdata;
            data_nx   = 32'd0;
            nbytes_nx = gnt_if ? IF_BYTES : len_bytes(lsb_len);
          end
        end
        ST_BUSY: begin
          if (is_wr) begin
            if (!io_stall) begin
              cnt_nx = cnt + 3'd1;
              if (cnt == nbytes - 3'd1) state_nx = ST_DONE;
            end
          end else begin
            // mem_din carries the byte addressed in the previous cycle.
            case (cnt)
              3'd1:    data_nx[7:0]   = mem_din;
              3'd2:    data_nx[15:8]  = mem_din;
              3'd3:    data_nx[23:16] = mem_din;
              3'd4:    data_nx[31:24] = mem_din;
              default: ;
            endcase
            if (cnt == nbytes) state_nx = ST_DONE;
            else               cnt_nx   = cnt + 3'd1;
          end
        end
        ST_DONE: state_nx = ST_IDLE;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // While paused, a load re-drives the byte whose data is still in flight.
  always_comb begin
    a_idx = cnt;
    if (!is_wr && !rdy_in && cnt != 3'd0) a_idx = cnt - 3'd1;
  end

  always_comb begin
    mem_a    = 32'd0;
    mem_dout = 8'd0;
    mem_wr   = 1'b0;
    if (state == ST_BUSY && !rst_in) begin
      if (is_wr || cnt != nbytes || !rdy_in) mem_a = addr + {29'd0, a_idx};
      if (is_wr) begin
        mem_dout = 8'(wdata >> {cnt[1:0], 3'b000});
        mem_wr   = rdy_in && !io_stall;
      end
    end
  end

  assign if_done   = (state == ST_DONE) && is_if && rdy_in && !rollback_in && !rst_in;
  assign lsb_done  = (state == ST_DONE) && !is_if && rdy_in && !abort && !rst_in;
  assign if_data   = data;
  assign lsb_rdata = data;

endmodule
